// File: rtl/foveation_region_classifier_if.sv
// foveation_region_classifier_if: pixel stream, gaze/threshold parameters and region-tagged output bundle
// master: upstream/source side (drives i_*), slave: classifier (drives o_*)
interface foveation_region_classifier_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] i_pix_data, o_pix_data;
  logic i_pix_valid, i_sof, i_eol;
  logic o_pix_valid, o_sof, o_eol, o_param_ready, o_frame_err;
  logic [10:0] i_gaze_x, i_gaze_y;
  logic [23:0] i_tres_1, i_tres_2, i_tres_3;
  logic [1:0] o_region;
  modport master (
    output i_pix_data, i_pix_valid, i_sof, i_eol, i_gaze_x, i_gaze_y, i_tres_1, i_tres_2, i_tres_3,
    input o_pix_data, o_pix_valid, o_sof, o_eol, o_region, o_param_ready, o_frame_err
  );
  modport slave (
    input i_pix_data, i_pix_valid, i_sof, i_eol, i_gaze_x, i_gaze_y, i_tres_1, i_tres_2, i_tres_3,
    output o_pix_data, o_pix_valid, o_sof, o_eol, o_region, o_param_ready, o_frame_err
  );
endinterface

// File: rtl/foveation_region_classifier.sv
// foveation_region_classifier: tags each raster pixel with a 2-bit region from its squared distance to the gaze point
// Ports: i_clk; i_rst_n (async, active-low); bus (slave) = pixel stream in/out, gaze + thresholds in,
//        o_region, o_param_ready (frame-boundary parameter strobe), o_frame_err (framing violation pulse)
module foveation_region_classifier #(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080
) (
  input logic i_clk,
  input logic i_rst_n,
  foveation_region_classifier_if.slave bus
);
  typedef enum logic [1:0] {WAIT_SOF, ACTIVE, FRAME_DONE} state_t;
  typedef struct packed {
    logic v;
    logic sof;
    logic eol;
    logic [DATA_WIDTH-1:0] d;
    logic [23:0] t1;
    logic [23:0] t2;
    logic [23:0] t3;
  } pl_t;
  localparam logic [10:0] XMAX = 11'(H_ACTIVE - 1);
  localparam logic [10:0] YMAX = 11'(V_ACTIVE - 1);
  state_t state_q, state_d;
  logic started_q, enter_q, ready_q, err_q, err_d, accept;
  logic [10:0] x_q, y_q, x_d, y_d, cx, cy, gx, gy, gx_q, gy_q, dx_d, dy_d, dx_q, dy_q;
  logic [23:0] t1_q, t2_q, t3_q;
  logic [21:0] sx_q, sy_q;
  logic [22:0] d2_q;
  pl_t s1_d, p1_q, p2_q, p3_q;
  logic ov_q, osof_q, oeol_q;
  logic [DATA_WIDTH-1:0] od_q;
  logic [1:0] region_q, region_d;
  // x_q/y_q hold the coordinate the next accepted pixel will take; an SOF pixel overrides it with (0,0)
  always_comb begin
    accept = bus.i_pix_valid & (state_q == ACTIVE | bus.i_sof);
    cx = bus.i_sof ? '0 : x_q;
    cy = bus.i_sof ? '0 : y_q;
    gx = bus.i_sof ? bus.i_gaze_x : gx_q;
    gy = bus.i_sof ? bus.i_gaze_y : gy_q;
    dx_d = cx >= gx ? cx - gx : gx - cx;
    dy_d = cy >= gy ? cy - gy : gy - cy;
    x_d = !accept ? x_q : bus.i_eol ? '0 : cx == XMAX ? XMAX : cx + 11'd1;
    y_d = !accept ? y_q : bus.i_eol ? cy + 11'd1 : cy;
    state_d = accept & bus.i_eol & cy == YMAX ? FRAME_DONE : accept & bus.i_sof ? ACTIVE : state_q;
    err_d = (accept & bus.i_sof & state_q == ACTIVE & (x_q != '0 | y_q != '0))
          | (accept & bus.i_eol & cx != XMAX)
          | (accept & ~bus.i_eol & cx == XMAX)
          | (bus.i_pix_valid & ~bus.i_sof & state_q != ACTIVE);
    s1_d.v = accept;
    s1_d.sof = bus.i_sof;
    s1_d.eol = bus.i_eol;
    s1_d.d = bus.i_pix_data;
    s1_d.t1 = bus.i_sof ? bus.i_tres_1 : t1_q;
    s1_d.t2 = bus.i_sof ? bus.i_tres_2 : t2_q;
    s1_d.t3 = bus.i_sof ? bus.i_tres_3 : t3_q;
    region_d = {1'b0, d2_q} < p3_q.t1 ? 2'd0 : {1'b0, d2_q} < p3_q.t2 ? 2'd1 : {1'b0, d2_q} < p3_q.t3 ? 2'd2 : 2'd3;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= WAIT_SOF;
      started_q <= 1'b0;
      enter_q <= 1'b0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      gx_q <= '0;
      gy_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
      t3_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      p3_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      d2_q <= '0;
      ov_q <= 1'b0;
      osof_q <= 1'b0;
      oeol_q <= 1'b0;
      od_q <= '0;
      region_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      if (accept & bus.i_sof) begin
        gx_q <= bus.i_gaze_x;
        gy_q <= bus.i_gaze_y;
        t1_q <= bus.i_tres_1;
        t2_q <= bus.i_tres_2;
        t3_q <= bus.i_tres_3;
      end
      // strobe once after reset release, and one cycle after entering FRAME_DONE
      started_q <= 1'b1;
      enter_q <= state_d == FRAME_DONE && state_q != FRAME_DONE;
      ready_q <= ~started_q | enter_q;
      err_q <= err_d;
      p1_q <= s1_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      p2_q <= p1_q;
      sx_q <= 22'(dx_q) * 22'(dx_q);
      sy_q <= 22'(dy_q) * 22'(dy_q);
      p3_q <= p2_q;
      d2_q <= {1'b0, sx_q} + {1'b0, sy_q};
      ov_q <= p3_q.v;
      osof_q <= p3_q.sof;
      oeol_q <= p3_q.eol;
      od_q <= p3_q.d;
      region_q <= region_d;
    end
  assign bus.o_pix_valid = ov_q;
  assign bus.o_sof = osof_q;
  assign bus.o_eol = oeol_q;
  assign bus.o_pix_data = od_q;
  assign bus.o_region = region_q;
  assign bus.o_param_ready = ready_q;
  assign bus.o_frame_err = err_q;
endmodule

// File: tb/tb_foveation_region_classifier.sv
// tb_foveation_region_classifier: randomized stimulus checked every cycle against a behavioural frame model
module tb_foveation_region_classifier;
  localparam int DW = 24;
  localparam int H = 8;
  localparam int V = 4;
  localparam int MAXC = 4096;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  foveation_region_classifier_if #(.DATA_WIDTH(DW)) bus();
  foveation_region_classifier #(.DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );
  typedef struct packed {
    logic v;
    logic s;
    logic e;
    logic [DW-1:0] d;
    logic [1:0] r;
  } exp_t;
  exp_t exp_o [MAXC];
  logic exp_e [MAXC];
  logic exp_p [MAXC];
  int tests = 0, fails = 0, pin_hits = 0;
  int cyc, mode, px, py, mx, my, mgx, mgy, mt1, mt2, mt3;
  logic acc, err;
  exp_t got, want;
  logic [7:0] ptag, pxx, pyy;

  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, g, e, $time);
    end
  endtask

  function automatic logic [1:0] region_of(int x, int y, int gx, int gy, int t1, int t2, int t3);
    int d2;
    d2 = (x - gx) * (x - gx) + (y - gy) * (y - gy);
    return d2 < t1 ? 2'd0 : d2 < t2 ? 2'd1 : d2 < t3 ? 2'd2 : 2'd3;
  endfunction

  // frame-level model: mode 0 waiting for SOF, 1 inside a frame, 2 frame finished
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAXC; i++) begin
        exp_o[i] = '0;
        exp_e[i] = 1'b0;
        exp_p[i] = 1'b0;
      end
      cyc = 0; mode = 0; px = 0; py = 0;
      mgx = 0; mgy = 0; mt1 = 0; mt2 = 0; mt3 = 0;
    end else begin
      acc = bus.i_pix_valid && (mode == 1 || bus.i_sof);
      err = bus.i_pix_valid && !acc;
      if (acc) begin
        if (bus.i_sof) begin
          if (mode == 1 && (px != 0 || py != 0)) err = 1'b1;
          px = 0; py = 0; mode = 1;
          mgx = int'(bus.i_gaze_x); mgy = int'(bus.i_gaze_y);
          mt1 = int'(bus.i_tres_1); mt2 = int'(bus.i_tres_2); mt3 = int'(bus.i_tres_3);
        end
        mx = px; my = py;
        if (cyc + 3 < MAXC)
          exp_o[cyc+3] = '{1'b1, bus.i_sof, bus.i_eol, bus.i_pix_data, region_of(mx, my, mgx, mgy, mt1, mt2, mt3)};
        if (bus.i_eol) begin
          if (mx != H - 1) err = 1'b1;
          px = 0; py = my + 1;
          if (my == V - 1) begin
            mode = 2;
            if (cyc + 1 < MAXC) exp_p[cyc+1] = 1'b1;
          end
        end else if (mx == H - 1) err = 1'b1;
        else px = mx + 1;
      end
      if (cyc < MAXC) exp_e[cyc] = err;
      if (cyc == 0) exp_p[0] = 1'b1;
      cyc++;
    end
  end

  always @(negedge clk) begin
    got = '{bus.o_pix_valid, bus.o_sof, bus.o_eol, bus.o_pix_data, bus.o_region};
    if (!rst_n || cyc == 0) chk("reset_outputs", {got, bus.o_frame_err, bus.o_param_ready}, 64'd0);
    else if (cyc <= MAXC) begin
      want = exp_o[cyc-1];
      chk("pix_valid", got.v, want.v);
      if (want.v) chk("pix", got, want);
      chk("frame_err", bus.o_frame_err, exp_e[cyc-1]);
      chk("param_ready", bus.o_param_ready, exp_p[cyc-1]);
    end
    if (rst_n && got.v) begin
      ptag = got.d[23:16]; pyy = got.d[15:8]; pxx = got.d[7:0];
      if (ptag == 8'd2 || ptag == 8'd5) begin
        if (pxx == 8'd3 && pyy == 8'd2) begin chk("pin_3_2", got.r, 0); pin_hits++; end
        if (pxx == 8'd5 && pyy == 8'd2) begin chk("pin_5_2", got.r, 1); pin_hits++; end
        if (pxx == 8'd4 && pyy == 8'd0) begin chk("pin_4_0", got.r, 2); pin_hits++; end
        if (pxx == 8'd0 && pyy == 8'd0) begin chk("pin_0_0", got.r, 3); pin_hits++; end
      end
      if (ptag == 8'd3 && pxx == 8'd3 && pyy == 8'd2) begin chk("pin_old_gaze", got.r, 0); pin_hits++; end
      if (ptag == 8'd4 && pxx == 8'd0 && pyy == 8'd0) begin chk("pin_new_gaze", got.r, 0); pin_hits++; end
      if (ptag == 8'd6 && pxx == 8'd0 && pyy == 8'd2) begin chk("pin_after_bad_eol", got.r, 2); pin_hits++; end
    end
  end

  task automatic drive(input logic v, input logic s, input logic e, input logic [DW-1:0] d);
    bus.i_pix_valid = v; bus.i_sof = s; bus.i_eol = e; bus.i_pix_data = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 1'($urandom), DW'($urandom));
  endtask

  task automatic set_params(input int gx, input int gy);
    bus.i_gaze_x = 11'(gx); bus.i_gaze_y = 11'(gy);
    bus.i_tres_1 = 24'd1; bus.i_tres_2 = 24'd5; bus.i_tres_3 = 24'd10;
  endtask

  task automatic frame(input int tag, input int gap, input int bad_row, input int chg);
    int k;
    int w;
    k = 0;
    for (int y = 0; y < V; y++) begin
      w = (y == bad_row) ? 6 : H;
      for (int x = 0; x < w; x++) begin
        while (int'($urandom_range(99)) < gap) idle(1);
        if (k == chg) begin bus.i_gaze_x = '0; bus.i_gaze_y = '0; end
        drive(1'b1, x == 0 && y == 0, x == w - 1, {8'(tag), 8'(y), 8'(x)});
        if (y == bad_row && x == w - 1) chk("eol_err_pulse", bus.o_frame_err, 1);
        k++;
      end
    end
  endtask

  task automatic wait_pr();
    int n;
    n = 0;
    while (bus.o_param_ready !== 1'b1 && n < 20) begin idle(1); n++; end
    chk("param_ready_seen", bus.o_param_ready, 1);
    idle(1);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    set_params(3, 2);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("reset_release_pr", bus.o_param_ready, 1);
    chk("reset_release_valid", bus.o_pix_valid, 0);
    idle(1);
    chk("reset_release_pr_end", bus.o_param_ready, 0);
    idle(2);
    frame(2, 0, -1, -1);
    chk("pr_not_yet", bus.o_param_ready, 0);
    idle(1);
    chk("pr_after_last_eol", bus.o_param_ready, 1);
    idle(1);
    frame(3, 0, -1, 10);
    wait_pr();
    frame(4, 0, -1, -1);
    set_params(3, 2);
    wait_pr();
    frame(5, 30, -1, -1);
    wait_pr();
    frame(6, 10, 1, -1);
    drive(1'b1, 1'b0, 1'b0, {8'hEE, 16'h0});
    chk("drop_err_pulse", bus.o_frame_err, 1);
    frame(7, 0, -1, -1);
    wait_pr();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(49) == 0) begin
        bus.i_gaze_x = 11'($urandom_range(H)); bus.i_gaze_y = 11'($urandom_range(V));
        bus.i_tres_1 = 24'($urandom_range(40)); bus.i_tres_2 = 24'($urandom_range(40));
        bus.i_tres_3 = 24'($urandom_range(40));
      end
      drive($urandom_range(3) != 0, $urandom_range(29) == 0, $urandom_range(7) == 0, {8'hEE, 16'($urandom)});
    end
    set_params(3, 2);
    idle(6);
    drive(1'b1, 1'b1, 1'b0, {8'hEE, 16'h1});
    drive(1'b1, 1'b0, 1'b0, {8'hEE, 16'h2});
    drive(1'b1, 1'b0, 1'b0, {8'hEE, 16'h3});
    bus.i_pix_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outputs",
           {bus.o_pix_valid, bus.o_sof, bus.o_eol, bus.o_pix_data, bus.o_region, bus.o_param_ready, bus.o_frame_err}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    chk("pin_hits", pin_hits, 11);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
